// File: rtl/instr_mem_arbiter.sv
// Two-port instruction-memory arbiter: fetch wins contention until debug has lost STARVE_LIMIT times.
// Grant is combinational; read data, valid and misalign return exactly one cycle after the grant.
module instr_mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_gnt,
   output logic        f_valid,
   output logic [31:0] f_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   output logic        d_gnt,
   output logic        d_valid,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic        misalign
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] r_starve_cnt;
   logic          r_f_valid;
   logic          r_d_valid;
   logic [31:0]   r_f_rdata;
   logic [31:0]   r_d_rdata;
   logic          r_misalign;

   logic          w_d_win;
   logic          w_f_win;
   logic          w_contested;
   logic [31:0]   w_gnt_addr;

   // Debug only wins contention once fetch has used up its allowance.
   always_comb begin
      w_contested = f_req && d_req;
      w_d_win     = !reset && d_req && (!f_req || (r_starve_cnt == LIMIT));
      w_f_win     = !reset && f_req && !w_d_win;
      w_gnt_addr  = 32'h0;
      if (w_f_win) begin
         w_gnt_addr = f_addr;
      end else if (w_d_win) begin
         w_gnt_addr = d_addr;
      end
   end

   assign f_gnt    = w_f_win;
   assign d_gnt    = w_d_win;
   assign mem_addr = {w_gnt_addr[31:2], 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_starve_cnt <= '0;
         r_f_valid    <= 1'b0;
         r_d_valid    <= 1'b0;
         r_f_rdata    <= 32'h0;
         r_d_rdata    <= 32'h0;
         r_misalign   <= 1'b0;
      end else begin
         r_f_valid  <= w_f_win;
         r_d_valid  <= w_d_win;
         r_misalign <= (w_f_win || w_d_win) && (w_gnt_addr[1:0] != 2'b00);
         if (w_f_win) begin
            r_f_rdata <= mem_rdata;
         end
         if (w_d_win) begin
            r_d_rdata <= mem_rdata;
         end
         if (w_d_win) begin
            r_starve_cnt <= '0;
         end else if (w_f_win && w_contested && (r_starve_cnt != LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + CW'(1);
         end
      end
   end

   assign f_valid  = r_f_valid;
   assign d_valid  = r_d_valid;
   assign f_rdata  = r_f_rdata;
   assign d_rdata  = r_d_rdata;
   assign misalign = r_misalign;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Randomized bench for instr_mem_arbiter against a transaction-level model with a behavioural memory.
module tb_instr_mem_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        f_req = 1'b0;
   logic [31:0] f_addr = 32'h0;
   logic        f_gnt;
   logic        f_valid;
   logic [31:0] f_rdata;
   logic        d_req = 1'b0;
   logic [31:0] d_addr = 32'h0;
   logic        d_gnt;
   logic        d_valid;
   logic [31:0] d_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        misalign;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int          m_losses;
   logic        e_fv, e_dv, e_mis;
   logic [31:0] e_frd, e_drd;

   instr_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .misalign(misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a == 32'h8) return 32'h2002_0005;
      return ((a ^ 32'h5A5A_0000) * 32'h0001_0003) + 32'h17;
   endfunction

   assign mem_rdata = word_at(mem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_losses = 0;
      e_fv = 1'b0; e_dv = 1'b0; e_mis = 1'b0;
      e_frd = 32'h0; e_drd = 32'h0;
   endtask

   // One clock: check last cycle's responses, drive new requests, check the grant.
   task automatic cycle(input logic fr, input logic [31:0] fa, input logic dr, input logic [31:0] da);
      logic gf, gd;
      logic [31:0] ga;
      @(posedge clk); #1;
      chk("f_valid", {31'b0, f_valid}, {31'b0, e_fv});
      chk("d_valid", {31'b0, d_valid}, {31'b0, e_dv});
      chk("f_rdata", f_rdata, e_frd);
      chk("d_rdata", d_rdata, e_drd);
      chk("misalign", {31'b0, misalign}, {31'b0, e_mis});
      f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
      #1;
      gd = dr && (!fr || (m_losses >= LIMIT));
      gf = fr && !gd;
      ga = gf ? fa : (gd ? da : 32'h0);
      chk("f_gnt", {31'b0, f_gnt}, {31'b0, gf});
      chk("d_gnt", {31'b0, d_gnt}, {31'b0, gd});
      chk("mem_addr", mem_addr, (gf || gd) ? (ga & 32'hFFFF_FFFC) : 32'h0);
      e_fv = gf;
      e_dv = gd;
      e_mis = (gf || gd) && (ga % 4 != 0);
      if (gf) e_frd = word_at(ga & 32'hFFFF_FFFC);
      if (gd) e_drd = word_at(ga & 32'hFFFF_FFFC);
      if (gd) m_losses = 0;
      else if (gf && dr && m_losses < LIMIT) m_losses++;
   endtask

   initial begin
      model_reset();
      #12;
      chk("rst f_gnt", {31'b0, f_gnt}, 32'h0);
      chk("rst f_valid", {31'b0, f_valid}, 32'h0);
      chk("rst f_rdata", f_rdata, 32'h0);
      chk("rst d_rdata", d_rdata, 32'h0);
      chk("rst misalign", {31'b0, misalign}, 32'h0);
      reset = 1'b0;

      // single fetch at 0x8
      cycle(1'b1, 32'h8, 1'b0, 32'h0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0);
      chk("fetch word 0x8", f_rdata, 32'h2002_0005);

      // sustained contention: debug at cycles 4 and 9
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 32'h100 + 32'(4 * i), 1'b1, 32'h200 + 32'(4 * i));
         chk("starve pattern", {31'b0, d_gnt}, {31'b0, (i == 4 || i == 9)});
      end
      // debug only at 0x10, then misaligned fetch at 0x6
      cycle(1'b0, 32'h0, 1'b1, 32'h10);
      cycle(1'b1, 32'h6, 1'b0, 32'h0);
      chk("misaligned mem_addr", mem_addr, 32'h4);
      // alternating single requests
      cycle(1'b1, 32'h0, 1'b0, 32'h0);
      cycle(1'b0, 32'h0, 1'b1, 32'h4);
      cycle(1'b1, 32'h8, 1'b0, 32'h0);
      cycle(1'b0, 32'h0, 1'b1, 32'hC);

      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0), $urandom);
      end
      cycle(1'b0, 32'h0, 1'b0, 32'h0);

      // asynchronous reset mid-cycle with a grant active
      cycle(1'b1, 32'h20, 1'b1, 32'h24);
      @(posedge clk); #1;
      f_req = 1'b1; f_addr = 32'h30; d_req = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("arst f_gnt", {31'b0, f_gnt}, 32'h0);
      chk("arst d_gnt", {31'b0, d_gnt}, 32'h0);
      chk("arst mem_addr", mem_addr, 32'h0);
      chk("arst f_valid", {31'b0, f_valid}, 32'h0);
      chk("arst d_valid", {31'b0, d_valid}, 32'h0);
      chk("arst f_rdata", f_rdata, 32'h0);
      chk("arst d_rdata", d_rdata, 32'h0);
      chk("arst misalign", {31'b0, misalign}, 32'h0);
      @(posedge clk); #1;
      f_req = 1'b0;
      #3;
      reset = 1'b0;
      model_reset();
      cycle(1'b0, 32'h0, 1'b0, 32'h0);
      cycle(1'b1, 32'h40, 1'b1, 32'h44);
      chk("post-reset contest", {31'b0, f_gnt}, 32'h1);
      cycle(1'b0, 32'h0, 1'b0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
